interboard_receiver: RTL and testbench

- Receiving end of the 4-phase Request/Ack board-to-board link that carries game messages between the master and slave Bingo boards.
- Synchronises the asynchronous Request_in line and acknowledges each 6-bit beat.
- Assembles two-beat frames into one message: {msg_type[2:0], number[4:0]}.
- Delivers each message to the game controller as a single-cycle interboard_en strobe, and decodes the reset message into interboard_rst.

---
 rtl/interboard_receiver.sv | 155 +++++++++++++++
 tb/tb_interboard_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/interboard_receiver.sv
// interboard_receiver
//   Receiving end of the 4-phase Request/Ack board-to-board link. It
//   synchronises Request_in and acknowledges each 6-bit beat. Two beats are
//   assembled into one {msg_type, number} message, which is delivered with a
//   single-cycle interboard_en strobe.
//
//   Frame: beat 0 = {msg_type[2:0], number[4:2]}
//          beat 1 = {number[1:0], 3'b000, p}   (p = even parity over message)
//
//   Optional feature: define INTERBOARD_PARITY_CHECK_EN to check p at delivery.
//   A frame with bad parity is then dropped and frame_err pulses instead.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   Request_in          request from the peer board (asynchronous to clk)
//   inter_data_in[5:0]  beat payload, stable while Request_in is high
//   Ack_out             registered acknowledge to the peer
//   interboard_en       one-cycle strobe: new message on msg_type/number
//   interboard_msg_type received message type, held until the next strobe
//   interboard_number   received number, held until the next strobe
//   interboard_rst      one-cycle pulse with interboard_en for RST_MSG_TYPE
//   rx_busy             high whenever the receiver is not idle
//   frame_err           one-cycle pulse on timeout (or parity error)

module interboard_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [2:0]  RST_MSG_TYPE   = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK0,
        WAIT1,
        ACK1,
        DELIVER
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [5:0]             beat0;
    logic [1:0]             num_lo;
    logic [CNT_W-1:0]       cnt;
    logic                   unused_bits;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign rx_busy = (state != IDLE);

`ifdef INTERBOARD_PARITY_CHECK_EN
    logic par;
    assign unused_bits = ^inter_data_in[3:1];
`else
    assign unused_bits = ^inter_data_in[3:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q              <= '0;
            state               <= IDLE;
            beat0               <= '0;
            num_lo              <= '0;
            cnt                 <= '0;
            Ack_out             <= 1'b0;
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            interboard_msg_type <= '0;
            interboard_number   <= '0;
            frame_err           <= 1'b0;
`ifdef INTERBOARD_PARITY_CHECK_EN
            par                 <= 1'b0;
`endif
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], Request_in};
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            frame_err      <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_s) begin
                        beat0   <= inter_data_in;
                        Ack_out <= 1'b1;
                        state   <= ACK0;
                    end
                end
                ACK0: begin
                    if (!req_s) begin
                        Ack_out <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT1;
                    end
                end
                WAIT1: begin
                    // A request seen on the expiry cycle still wins.
                    if (req_s) begin
                        num_lo  <= inter_data_in[5:4];
`ifdef INTERBOARD_PARITY_CHECK_EN
                        par     <= inter_data_in[0];
`endif
                        Ack_out <= 1'b1;
                        state   <= ACK1;
                    end else if (cnt == CNT_LAST) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK1: begin
                    if (!req_s) begin
                        Ack_out <= 1'b0;
                        state   <= DELIVER;
                    end
                end
                DELIVER: begin
`ifdef INTERBOARD_PARITY_CHECK_EN
                    if ((^{beat0, num_lo}) != par) begin
                        frame_err <= 1'b1;
                    end else begin
                        interboard_msg_type <= beat0[5:3];
                        interboard_number   <= {beat0[2:0], num_lo};
                        interboard_en       <= 1'b1;
                        interboard_rst      <= (beat0[5:3] == RST_MSG_TYPE);
                    end
`else
                    interboard_msg_type <= beat0[5:3];
                    interboard_number   <= {beat0[2:0], num_lo};
                    interboard_en       <= 1'b1;
                    interboard_rst      <= (beat0[5:3] == RST_MSG_TYPE);
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interboard_receiver.sv
// tb_interboard_receiver
//   Randomized bench for interboard_receiver with a message-level reference
//   model: the peer driver pushes each message it expects to be delivered,
//   and a compare process checks the DUT outputs every cycle against the
//   model's held message and the reset-message rule.

module tb_interboard_receiver;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TO   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Request_in = 1'b0;
    logic [5:0] inter_data_in = '0;
    logic       Ack_out;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;
    logic       interboard_rst;
    logic       rx_busy;
    logic       frame_err;

    interboard_receiver #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TO),
        .RST_MSG_TYPE  (3'b000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .Request_in         (Request_in),
        .inter_data_in      (inter_data_in),
        .Ack_out            (Ack_out),
        .interboard_en      (interboard_en),
        .interboard_msg_type(interboard_msg_type),
        .interboard_number  (interboard_number),
        .interboard_rst     (interboard_rst),
        .rx_busy            (rx_busy),
        .frame_err          (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] t;
        logic [4:0] n;
    } msg_t;

    msg_t       exp_q[$];
    logic [2:0] m_type = '0;
    logic [4:0] m_num  = '0;
    int         errors = 0;
    int         checks = 0;
    int         dut_ferr = 0;
    int         exp_ferr = 0;

`ifdef INTERBOARD_PARITY_CHECK_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_ack", Ack_out, 0);
            check("rst_en", interboard_en, 0);
            check("rst_busy", rx_busy, 0);
            check("rst_ferr", frame_err, 0);
            check("rst_msg_type", interboard_msg_type, 0);
            check("rst_number", interboard_number, 0);
        end else begin
            if (interboard_en) begin
                check("en_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    msg_t e;
                    e = exp_q.pop_front();
                    m_type = e.t;
                    m_num  = e.n;
                end
            end
            check("msg_type", interboard_msg_type, m_type);
            check("number", interboard_number, m_num);
            check("rst_pulse", interboard_rst, interboard_en && (m_type == 3'b000));
            if (frame_err) dut_ferr++;
        end
    end

    task automatic raise_beat(input logic [5:0] d);
        int n;
        @(negedge clk);
        inter_data_in = d;
        Request_in    = 1'b1;
        n = 0;
        while (!Ack_out && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ack_rise_latency", n, SYNC + 1);
    endtask

    task automatic drop_beat();
        int n;
        @(negedge clk);
        Request_in = 1'b0;
        n = 0;
        while (Ack_out && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ack_fall_latency", n, SYNC + 1);
        inter_data_in = 6'($urandom);
    endtask

    // gap: idle negedges between beats. Gaps beyond TO send beat 0 only.
    task automatic send_frame(input logic [2:0] t, input logic [4:0] n,
                              input int gap, input bit corrupt);
        logic p;
        bit   deliver;
        msg_t m;
        p = (^{t, n}) ^ corrupt;
        raise_beat({t, n[4:2]});
        drop_beat();
        repeat (gap) @(negedge clk);
        if (gap > int'(TO)) begin
            exp_ferr++;
            repeat (5) @(negedge clk);
            check("busy_after_timeout", rx_busy, 0);
            check("ferr_count_timeout", dut_ferr, exp_ferr);
            return;
        end
        raise_beat({n[1:0], 3'b000, p});
        deliver = !(PARITY_ON && corrupt);
        if (deliver) begin
            m.t = t;
            m.n = n;
            exp_q.push_back(m);
        end else begin
            exp_ferr++;
        end
        drop_beat();
        // interboard_en lands two cycles after req_s falls, one after Ack falls.
        @(posedge clk); #1;
        check("en_latency", interboard_en, deliver);
        check("ferr_at_deliver", frame_err, !deliver);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_type = '0;
        m_num  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with Request_in toggling: everything stays at 0.
        repeat (3) begin
            @(negedge clk); Request_in = 1'b1; inter_data_in = 6'h2A;
            repeat (3) @(negedge clk);
            Request_in = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Normal frame: msg_type 010, number 22.
        send_frame(3'b010, 5'd22, 3, 1'b0);
        check("lit_type_22", interboard_msg_type, 3'b010);
        check("lit_number_22", interboard_number, 22);

        // Reset message.
        send_frame(3'b000, 5'd0, 2, 1'b0);
        check("lit_rst_en", interboard_en, 1);
        check("lit_rst_pulse", interboard_rst, 1);

        // Timeout, then a frame carrying 7.
        send_frame(3'b101, 5'd9, TO + 20, 1'b0);
        send_frame(3'b001, 5'd7, 4, 1'b0);
        check("lit_number_7", interboard_number, 7);
        check("lit_type_7", interboard_msg_type, 3'b001);

        // Asynchronous reset while in ACK1.
        raise_beat({3'b011, 3'b110});
        drop_beat();
        raise_beat({2'b01, 3'b000, 1'b0});
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("ack_drop_on_reset", Ack_out, 0);
        Request_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(3'b110, 5'd19, 1, 1'b0);
        check("lit_after_reset_num", interboard_number, 19);

`ifdef INTERBOARD_PARITY_CHECK_EN
        // Wrong parity: dropped, outputs keep 19 / 110.
        send_frame(3'b100, 5'd3, 2, 1'b1);
        check("lit_par_hold_num", interboard_number, 19);
        check("lit_par_hold_type", interboard_msg_type, 3'b110);
`endif

        // Randomized frames: back-to-back, short gaps, occasional timeouts.
        for (int i = 0; i < 60; i++) begin
            int gap;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      gap = int'($urandom_range(TO + 10, TO + 30));
            else if (sel < 3)  gap = 0;
            else               gap = int'($urandom_range(0, TO - 10));
            send_frame(3'($urandom), 5'($urandom), gap, ($urandom_range(0, 7) == 0));
        end

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("ferr_total", dut_ferr, exp_ferr);
        check("final_idle", rx_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
